// File: rtl/mem_channel_controller_pkg.sv
// Shared definitions for the multi-channel byte-serial memory controller:
// FSM states, access-size codes and the IO address window.
package mem_channel_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] IO_SPACE  = 2'b11;

  // Size code 2'b11 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_SPACE;
  endfunction

endpackage

// File: rtl/mem_channel_controller_if.sv
// Request channels plus the byte-serial RAM/IO bus. The master side is the
// requesters together with the RAM; the slave side is the controller.
interface mem_channel_controller_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0]    chFlag;
  logic [NUM_CH-1:0]    chWrite;
  logic [2*NUM_CH-1:0]  chSize;
  logic [32*NUM_CH-1:0] chAddr;
  logic [32*NUM_CH-1:0] chData;
  logic [NUM_CH-1:0]    okFlag;
  logic [31:0]          dataOut;
  logic                 ramSelect;
  logic [31:0]          ramAddr;
  logic [7:0]           ramOut;
  logic [7:0]           ramIn;
  logic                 ioBufferFull;

  modport master (
    output chFlag, chWrite, chSize, chAddr, chData, ramIn, ioBufferFull,
    input  okFlag, dataOut, ramSelect, ramAddr, ramOut
  );

  modport slave (
    input  chFlag, chWrite, chSize, chAddr, chData, ramIn, ioBufferFull,
    output okFlag, dataOut, ramSelect, ramAddr, ramOut
  );
endinterface

// File: rtl/mem_channel_controller_rr_arbiter.sv
// One-hot grant over NUM_CH requests, either fixed priority (lowest index)
// or round-robin starting from the supplied pointer.
module rr_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int ARB_MODE = 1,
  parameter int IDX_W    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              any_o
);
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] ch;

  assign start = (ARB_MODE != 0) ? ptr_i : '0;

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    ch        = '0;
    // Walk the search order backwards so the earliest requester is written last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      ch = IDX_W'((int'(start) + k) % NUM_CH);
      if (req_i[ch]) begin
        gnt_o     = NUM_CH'(1) << ch;
        gnt_idx_o = ch;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_channel_controller.sv
// Arbitrates NUM_CH requesters onto one byte-serial RAM/IO bus, serialising
// byte/half/word accesses, stalling IO writes and squashing flushed reads.
module mem_channel_controller
  import mem_channel_controller_pkg::*;
#(
  parameter int              NUM_CH     = 3,
  parameter int              ARB_MODE   = 1,
  parameter logic [NUM_CH-1:0] CLEAR_MASK = NUM_CH'(3'b110),
  parameter bit              IO_STALL   = 1'b1
) (
  input logic clockIn,
  input logic resetIn,
  input logic readyIn,
  input logic clearIn,
  mem_channel_controller_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  state_e            state_q;
  logic [2:0]        cyc_q;
  logic [2:0]        nbytes_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [31:0]       buf_q;
  logic [NUM_CH-1:0] okFlag_q;
  logic [31:0]       dataOut_q;
  logic              ramSelect_q;
  logic [31:0]       ramAddr_q;
  logic [7:0]        ramOut_q;

  logic [NUM_CH-1:0] eligible, gnt;
  logic [IDX_W-1:0]  gnt_idx, next_ptr;
  logic              gnt_any;
  logic [31:0]       sel_addr, sel_data, cur_addr, cur_data, issue_addr, cap_word;
  logic [1:0]        sel_size, cap_lane;
  logic              sel_write, wr_stall;
  logic [2:0]        cur_c;
  logic [7:0]        wr_byte;

  // A flush makes killable reads invisible to arbitration on that edge.
  assign eligible = bus.chFlag & ~(clearIn ? (CLEAR_MASK & ~bus.chWrite) : '0);

  rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE), .IDX_W(IDX_W)) u_arb (
    .req_i    (eligible),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .any_o    (gnt_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_size  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr  = bus.chAddr[i*32 +: 32];
        sel_data  = bus.chData[i*32 +: 32];
        sel_size  = bus.chSize[i*2 +: 2];
        sel_write = bus.chWrite[i];
      end
    end
  end

  // Byte 0 goes out on the grant edge itself, so IDLE issues from the live channel.
  assign cur_addr   = (state_q == ST_IDLE) ? sel_addr : addr_q;
  assign cur_data   = (state_q == ST_IDLE) ? sel_data : data_q;
  assign cur_c      = (state_q == ST_IDLE) ? 3'd0 : cyc_q;
  assign issue_addr = cur_addr + 32'(cur_c);
  assign wr_byte    = 8'(cur_data >> {cur_c[1:0], 3'b000});
  assign wr_stall   = IO_STALL && is_io(issue_addr) && bus.ioBufferFull;
  assign cap_lane   = 2'(cyc_q - 3'd2);
  assign cap_word   = buf_q | (32'(bus.ramIn) << {cap_lane, 3'b000});
  assign next_ptr   = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      nbytes_q    <= '0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      buf_q       <= '0;
      okFlag_q    <= '0;
      dataOut_q   <= '0;
      ramSelect_q <= 1'b0;
      ramAddr_q   <= '0;
      ramOut_q    <= '0;
    end else if (readyIn) begin
      okFlag_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          ramSelect_q <= 1'b0;
          ramAddr_q   <= '0;
          ramOut_q    <= '0;
          if (gnt_any) begin
            ptr_q     <= next_ptr;
            gnt_idx_q <= gnt_idx;
            addr_q    <= sel_addr;
            data_q    <= sel_data;
            nbytes_q  <= size_bytes(sel_size);
            buf_q     <= '0;
            if (!sel_write) begin
              state_q   <= ST_RD;
              cyc_q     <= 3'd1;
              ramAddr_q <= issue_addr;
            end else if (wr_stall) begin
              state_q <= ST_WR;
              cyc_q   <= 3'd0;
            end else begin
              ramSelect_q <= 1'b1;
              ramAddr_q   <= issue_addr;
              ramOut_q    <= wr_byte;
              if (size_bytes(sel_size) == 3'd1) begin
                okFlag_q <= gnt;
              end else begin
                state_q <= ST_WR;
                cyc_q   <= 3'd1;
              end
            end
          end
        end
        ST_WR: begin
          if (wr_stall) begin
            ramSelect_q <= 1'b0;
            ramAddr_q   <= '0;
            ramOut_q    <= '0;
          end else begin
            ramSelect_q <= 1'b1;
            ramAddr_q   <= issue_addr;
            ramOut_q    <= wr_byte;
            cyc_q       <= cyc_q + 3'd1;
            if (cyc_q == nbytes_q - 3'd1) begin
              okFlag_q <= NUM_CH'(1) << gnt_idx_q;
              state_q  <= ST_IDLE;
            end
          end
        end
        ST_RD: begin
          if (clearIn && CLEAR_MASK[gnt_idx_q]) begin
            state_q     <= ST_IDLE;
            ramSelect_q <= 1'b0;
            ramAddr_q   <= '0;
          end else begin
            // Once every byte is out, park the address so IO is not re-read.
            ramAddr_q <= (cyc_q < nbytes_q) ? issue_addr : '0;
            cyc_q     <= cyc_q + 3'd1;
            if (cyc_q >= 3'd2) buf_q <= cap_word;
            if (cyc_q == nbytes_q + 3'd1) begin
              okFlag_q  <= NUM_CH'(1) << gnt_idx_q;
              dataOut_q <= cap_word;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.okFlag    = okFlag_q;
  assign bus.dataOut   = dataOut_q;
  assign bus.ramSelect = ramSelect_q;
  assign bus.ramAddr   = ramAddr_q;
  assign bus.ramOut    = ramOut_q;

endmodule

// File: tb/tb_mem_channel_controller.sv
// Directed bench for mem_channel_controller: a round-robin instance with a
// RAM model plus a fixed-priority instance for the arbitration comparison.
module tb_mem_channel_controller;

  logic clk = 1'b0;
  logic resetIn, readyIn, clearIn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wr_count = 0;
  int   w0;
  logic [7:0] mem [logic [31:0]];

  mem_channel_controller_if #(.NUM_CH(3)) bus ();
  mem_channel_controller_if #(.NUM_CH(3)) bus_fp ();

  mem_channel_controller #(.NUM_CH(3), .ARB_MODE(1)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn), .bus(bus)
  );

  mem_channel_controller #(.NUM_CH(3), .ARB_MODE(0)) dut_fp (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn), .bus(bus_fp)
  );

  always #5 clk = ~clk;

  // RAM: address registered on one edge, data visible to the controller at the next.
  always @(posedge clk) begin
    if (bus.ramSelect) begin
      mem[bus.ramAddr] = bus.ramOut;
      wr_count <= wr_count + 1;
    end
    bus.ramIn <= mem.exists(bus.ramAddr) ? mem[bus.ramAddr] : 8'h00;
  end

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
    bus.chFlag  = bus.chFlag | (3'b001 << ch);
    bus.chWrite = (bus.chWrite & ~(3'b001 << ch)) | ({2'b00, wr} << ch);
    bus.chSize[2*ch +: 2]  = size;
    bus.chAddr[32*ch +: 32] = addr;
    bus.chData[32*ch +: 32] = data;
  endtask

  initial begin
    resetIn = 1'b0;
    readyIn = 1'b1;
    clearIn = 1'b0;
    bus.chFlag = '0; bus.chWrite = '0; bus.chSize = '0; bus.chAddr = '0; bus.chData = '0;
    bus.ioBufferFull = 1'b0;
    bus_fp.chFlag = '0; bus_fp.chWrite = '0; bus_fp.chSize = '0;
    bus_fp.chAddr = '0; bus_fp.chData = '0; bus_fp.ramIn = '0; bus_fp.ioBufferFull = 1'b0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h200] = 8'hAA; mem[32'h201] = 8'hBB;

    repeat (2) tick();
    check("rst_okflag", 32'(bus.okFlag), 32'h0);
    check("rst_ramaddr", bus.ramAddr, 32'h0);
    resetIn = 1'b1;
    tick();

    // Reset asserted in the middle of a word read.
    set_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();
    tick();
    check("midrd_addr", bus.ramAddr, 32'h101);
    bus.chFlag = '0;
    #2 resetIn = 1'b0;
    #1;
    check("async_rst_ramaddr", bus.ramAddr, 32'h0);
    check("async_rst_okflag", 32'(bus.okFlag), 32'h0);
    check("async_rst_ramsel", 32'(bus.ramSelect), 32'h0);
    check("async_rst_dataout", bus.dataOut, 32'h0);
    tick();
    resetIn = 1'b1;
    tick();

    // All three channels issue byte writes continuously.
    set_req(0, 1'b1, 2'b00, 32'h10, 32'h01);
    set_req(1, 1'b1, 2'b00, 32'h11, 32'h02);
    set_req(2, 1'b1, 2'b00, 32'h12, 32'h03);
    bus_fp.chFlag = bus.chFlag; bus_fp.chWrite = bus.chWrite; bus_fp.chSize = bus.chSize;
    bus_fp.chAddr = bus.chAddr; bus_fp.chData = bus.chData;
    tick();
    check("rr_g0", 32'(bus.okFlag), 32'h1);
    check("fp_g0", 32'(bus_fp.okFlag), 32'h1);
    tick();
    check("rr_g1", 32'(bus.okFlag), 32'h2);
    check("rr_g1_addr", bus.ramAddr, 32'h11);
    check("fp_g1", 32'(bus_fp.okFlag), 32'h1);
    tick();
    check("rr_g2", 32'(bus.okFlag), 32'h4);
    check("fp_g2", 32'(bus_fp.okFlag), 32'h1);
    tick();
    check("rr_g3", 32'(bus.okFlag), 32'h1);
    bus.chFlag = '0;
    bus_fp.chFlag = '0;
    tick();
    check("wr_mem_12", 32'(rd_mem(32'h12)), 32'h03);

    // ch1 word read, result five edges after the grant.
    set_req(1, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();
    check("rd_grant_addr", bus.ramAddr, 32'h100);
    check("rd_grant_sel", 32'(bus.ramSelect), 32'h0);
    repeat (4) tick();
    check("rd_t4_okflag", 32'(bus.okFlag), 32'h0);
    tick();
    check("rd_t5_okflag", 32'(bus.okFlag), 32'h2);
    check("rd_t5_data", bus.dataOut, 32'h44332211);
    bus.chFlag = '0;

    // IO byte write held while the UART buffer is full.
    set_req(2, 1'b1, 2'b00, 32'h30000, 32'h41);
    bus.ioBufferFull = 1'b1;
    w0 = wr_count;
    tick();
    check("io_stall_sel0", 32'(bus.ramSelect), 32'h0);
    check("io_stall_addr0", bus.ramAddr, 32'h0);
    tick();
    tick();
    check("io_stall_sel2", 32'(bus.ramSelect), 32'h0);
    check("io_stall_ok2", 32'(bus.okFlag), 32'h0);
    check("io_stall_nowr", 32'(wr_count - w0), 32'h0);
    bus.ioBufferFull = 1'b0;
    tick();
    check("io_wr_sel", 32'(bus.ramSelect), 32'h1);
    check("io_wr_addr", bus.ramAddr, 32'h30000);
    check("io_wr_byte", 32'(bus.ramOut), 32'h41);
    check("io_wr_ok", 32'(bus.okFlag), 32'h4);
    bus.chFlag = '0;
    tick();
    check("io_after_sel", 32'(bus.ramSelect), 32'h0);
    check("io_wr_count", 32'(wr_count - w0), 32'h1);
    check("io_mem", 32'(rd_mem(32'h30000)), 32'h41);

    // Flush kills a ch1 half read; a ch0 read then ignores a flush.
    set_req(1, 1'b0, 2'b01, 32'h200, 32'h0);
    tick();
    check("clr_grant_addr", bus.ramAddr, 32'h200);
    clearIn = 1'b1;
    tick();
    check("clr_abort_ok", 32'(bus.okFlag), 32'h0);
    check("clr_abort_addr", bus.ramAddr, 32'h0);
    clearIn = 1'b0;
    bus.chFlag = '0;
    set_req(0, 1'b0, 2'b01, 32'h200, 32'h0);
    tick();
    check("clr_ch0_grant", bus.ramAddr, 32'h200);
    clearIn = 1'b1;
    tick();
    check("clr_ch0_cont", bus.ramAddr, 32'h201);
    check("clr_ch0_ok1", 32'(bus.okFlag), 32'h0);
    clearIn = 1'b0;
    tick();
    check("clr_ch0_ok2", 32'(bus.okFlag), 32'h0);
    tick();
    check("clr_ch0_done", 32'(bus.okFlag), 32'h1);
    check("clr_ch0_data", bus.dataOut, 32'h0000BBAA);
    bus.chFlag = '0;

    // readyIn low for four cycles in the middle of a word write.
    set_req(0, 1'b1, 2'b10, 32'h400, 32'hDDCCBBAA);
    tick();
    check("frz_b0_addr", bus.ramAddr, 32'h400);
    check("frz_b0_byte", 32'(bus.ramOut), 32'hAA);
    tick();
    check("frz_b1_addr", bus.ramAddr, 32'h401);
    readyIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_hold_addr", bus.ramAddr, 32'h401);
    end
    readyIn = 1'b1;
    tick();
    check("frz_b2_addr", bus.ramAddr, 32'h402);
    check("frz_b2_ok", 32'(bus.okFlag), 32'h0);
    tick();
    check("frz_b3_byte", 32'(bus.ramOut), 32'hDD);
    check("frz_b3_ok", 32'(bus.okFlag), 32'h1);
    bus.chFlag = '0;
    tick();
    check("frz_idle_sel", 32'(bus.ramSelect), 32'h0);
    check("frz_mem", {rd_mem(32'h403), rd_mem(32'h402), rd_mem(32'h401), rd_mem(32'h400)},
          32'hDDCCBBAA);

    // Half write that wraps the 32-bit address space.
    set_req(0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_5A6B);
    tick();
    check("wrap_b0_addr", bus.ramAddr, 32'hFFFF_FFFF);
    check("wrap_b0_ok", 32'(bus.okFlag), 32'h0);
    tick();
    check("wrap_b1_addr", bus.ramAddr, 32'h0);
    check("wrap_b1_byte", 32'(bus.ramOut), 32'h5A);
    check("wrap_b1_ok", 32'(bus.okFlag), 32'h1);
    bus.chFlag = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
